// File: rtl/mem_responder_512x8_pkg.sv
// Shared encodings for the MFA/MFC memory responder and the control unit that drives it.
package mem_responder_512x8_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_512x8_byte_lane_ctrl.sv
// Maps a captured size/address to four big-endian byte lanes plus the reject flag.
// MEM_ALIGN_CHECK_EN additionally rejects misaligned halfword/word accesses.
module mem_byte_lane_ctrl
  import mem_responder_512x8_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [1:0]          i_size,
  input  logic [AW-1:0]       i_addr,
  output logic [3:0][AW-1:0]  o_lane_addr,
  output logic [3:0]          o_lane_en,
  output logic [3:0][1:0]     o_lane_sel,
  output logic                o_reject
);

  logic [2:0] w_nbytes;

  // Lane k touches mem[A+k]; it carries data byte (nbytes-1-k), MS byte first.
  always_comb begin
    w_nbytes    = size_bytes(i_size);
    o_lane_addr = '0;
    o_lane_en   = '0;
    o_lane_sel  = '0;
    for (int k = 0; k < 4; k++) begin
      o_lane_addr[k] = i_addr + AW'(k);
      o_lane_en[k]   = (3'(k) < w_nbytes);
      if (o_lane_en[k]) o_lane_sel[k] = 2'(w_nbytes - 3'(k) - 3'd1);
    end
  end

  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    o_reject = (i_size == SIZE_BAD)
             || ((i_size == SIZE_HALF) && i_addr[0])
             || ((i_size == SIZE_WORD) && (i_addr[1:0] != 2'b00));
`else
    o_reject = (i_size == SIZE_BAD);
`endif
  end

endmodule

// File: rtl/mem_responder_512x8.sv
// 512-byte big-endian memory responder on the MFA/MFC four-phase handshake.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
//
// state   | meaning
// IDLE    | waiting for MFA; request registers capture on MFA=1
// BUSY    | latency countdown; access performed when counter hits 0
// DONE    | MFC raised on entry edge+1, held until MFA sampled low
module mem_responder_512x8
  import mem_responder_512x8_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512,
  parameter int AW      = 9
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          memFuncActive,
  input  logic          readWrite,
  input  logic [AW-1:0] address,
  input  logic [31:0]   dataIn,
  input  logic [1:0]    dataSize,
  output logic [31:0]   dataOut,
  output logic          memFuncComplete,
  output logic          busError
);

  state_e        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [1:0]    r_size, w_size_nxt;
  logic          r_rw, w_rw_nxt;
  logic [31:0]   r_din, w_din_nxt;
  logic [31:0]   r_dout, w_dout_nxt;
  logic          r_mfc, w_mfc_nxt;
  logic          r_berr, w_berr_nxt;
  logic          w_commit;

  logic [7:0]    r_mem [DEPTH];

  logic [3:0][AW-1:0] w_lane_addr;
  logic [3:0]         w_lane_en;
  logic [3:0][1:0]    w_lane_sel;
  logic               w_reject;
  logic [31:0]        w_rd_data;

  mem_byte_lane_ctrl #(.AW(AW)) u_lane (
    .i_size      (r_size),
    .i_addr      (r_addr),
    .o_lane_addr (w_lane_addr),
    .o_lane_en   (w_lane_en),
    .o_lane_sel  (w_lane_sel),
    .o_reject    (w_reject)
  );

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane_en[k]) w_rd_data[{w_lane_sel[k], 3'b000} +: 8] = r_mem[w_lane_addr[k]];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_size_nxt  = r_size;
    w_rw_nxt    = r_rw;
    w_din_nxt   = r_din;
    w_dout_nxt  = r_dout;
    w_mfc_nxt   = r_mfc;
    w_berr_nxt  = r_berr;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (memFuncActive) begin
          w_addr_nxt  = address;
          w_size_nxt  = dataSize;
          w_rw_nxt    = readWrite;
          w_din_nxt   = dataIn;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
          if (w_reject)              w_dout_nxt = '0;
          else if (r_rw == RW_READ)  w_dout_nxt = w_rd_data;
          else                       w_commit   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        // MFC is raised unconditionally once, so an aborted request still sees one pulse.
        if (!r_mfc) begin
          w_mfc_nxt  = 1'b1;
          w_berr_nxt = w_reject;
        end else if (!memFuncActive) begin
          w_mfc_nxt   = 1'b0;
          w_berr_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_size  <= '0;
      r_rw    <= 1'b0;
      r_din   <= '0;
      r_dout  <= '0;
      r_mfc   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_size  <= w_size_nxt;
      r_rw    <= w_rw_nxt;
      r_din   <= w_din_nxt;
      r_dout  <= w_dout_nxt;
      r_mfc   <= w_mfc_nxt;
      r_berr  <= w_berr_nxt;
    end
  end

  // Storage survives reset; commits are gated by the FSM, which reset forces to IDLE.
  always_ff @(posedge Clk) begin
    if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[k]) r_mem[w_lane_addr[k]] <= r_din[{w_lane_sel[k], 3'b000} +: 8];
      end
    end
  end

  assign dataOut         = r_dout;
  assign memFuncComplete = r_mfc;
  assign busError        = r_berr;

endmodule

// File: tb/tb_mem_responder_512x8.sv
// Self-checking bench for mem_responder_512x8: vector table, handshake corner cases,
// and randomized traffic against a byte-array reference model.
module tb_mem_responder_512x8;

  localparam int LAT = 2;

  logic        Clk;
  logic        reset;
  logic        memFuncActive;
  logic        readWrite;
  logic [8:0]  address;
  logic [31:0] dataIn;
  logic [1:0]  dataSize;
  logic [31:0] dataOut;
  logic        memFuncComplete;
  logic        busError;

  mem_responder_512x8 #(.LATENCY(LAT), .DEPTH(512), .AW(9)) dut (
    .Clk             (Clk),
    .reset           (reset),
    .memFuncActive   (memFuncActive),
    .readWrite       (readWrite),
    .address         (address),
    .dataIn          (dataIn),
    .dataSize        (dataSize),
    .dataOut         (dataOut),
    .memFuncComplete (memFuncComplete),
    .busError        (busError)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  model_mem [512];
  logic [31:0] model_dout;

  typedef struct {
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic [31:0] din;
    logic [31:0] exp;
    logic        exp_berr;
  } tv_t;

  tv_t tv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: a request is n consecutive bytes (mod 512) starting at A, MS byte first.
  // Rejected requests touch nothing and leave dataOut at 0.
  task automatic model_access(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                              input logic [31:0] d, output logic [31:0] e_dout,
                              output logic e_berr);
    int n;
    logic rej;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    rej = (n == 0);
`ifdef MEM_ALIGN_CHECK_EN
    if ((n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0)) rej = 1'b1;
`endif
    e_berr = rej;
    if (rej) begin
      model_dout = 32'h0;
    end else if (rw) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[(int'(a) + i) % 512]);
      model_dout = v;
    end else begin
      for (int i = 0; i < n; i++) model_mem[(int'(a) + i) % 512] = 8'(d >> (8 * (n - 1 - i)));
    end
    e_dout = model_dout;
  endtask

  task automatic do_req(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] dout, output logic berr);
    int n;
    @(negedge Clk);
    memFuncActive = 1'b1;
    readWrite     = rw;
    address       = a;
    dataSize      = sz;
    dataIn        = d;
    @(posedge Clk); #1;
    address   = 9'($urandom);
    dataIn    = $urandom;
    dataSize  = 2'($urandom);
    readWrite = 1'($urandom);
    n = 0;
    while (!memFuncComplete && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("latency_edges", 32'(n), 32'(LAT + 1));
    dout = dataOut;
    berr = busError;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("mfc_held", 32'(memFuncComplete), 32'd1);
      chk("dout_stable", dataOut, dout);
    end
    @(negedge Clk);
    memFuncActive = 1'b0;
    @(posedge Clk); #1;
    chk("mfc_fall", 32'(memFuncComplete), 32'd0);
    chk("berr_fall", 32'(busError), 32'd0);
  endtask

  initial begin
    logic [31:0] d, e, last_exp;
    logic        b, eb;
    int          n;

    memFuncActive = 1'b0;
    readWrite     = 1'b0;
    address       = '0;
    dataIn        = '0;
    dataSize      = '0;
    reset         = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_dout", dataOut, 32'h0);
    chk("rst_mfc", 32'(memFuncComplete), 32'd0);
    chk("rst_berr", 32'(busError), 32'd0);
    #20 reset = 1'b1;

    model_dout = 32'h0;
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      do_req(1'b0, 9'(4 * w), 2'b10, d, 0, e, b);
      model_access(1'b0, 9'(4 * w), 2'b10, d, e, eb);
    end

    tv[0]  = '{1'b0, 9'h010, 2'b10, 32'hDEADBEEF, 32'h0,        1'b0};
    tv[1]  = '{1'b1, 9'h010, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 9'h011, 2'b00, 32'h0,        32'h000000AD, 1'b0};
    tv[3]  = '{1'b0, 9'h020, 2'b10, 32'h12345678, 32'h0,        1'b0};
    tv[4]  = '{1'b1, 9'h020, 2'b11, 32'h0,        32'h0,        1'b1};
    tv[5]  = '{1'b1, 9'h020, 2'b10, 32'h0,        32'h12345678, 1'b0};
    tv[6]  = '{1'b0, 9'h000, 2'b10, 32'hCAFEF00D, 32'h0,        1'b0};
    tv[7]  = '{1'b0, 9'h004, 2'b10, 32'h11223344, 32'h0,        1'b0};
`ifdef MEM_ALIGN_CHECK_EN
    tv[8]  = '{1'b1, 9'h002, 2'b10, 32'h0,        32'h0,        1'b1};
    tv[9]  = '{1'b0, 9'h1FE, 2'b01, 32'h0000A55A, 32'h0,        1'b0};
    tv[10] = '{1'b1, 9'h1FE, 2'b00, 32'h0,        32'h000000A5, 1'b0};
    tv[11] = '{1'b1, 9'h1FF, 2'b00, 32'h0,        32'h0000005A, 1'b0};
    tv[12] = '{1'b1, 9'h1FF, 2'b01, 32'h0,        32'h0,        1'b1};
    tv[13] = '{1'b1, 9'h000, 2'b10, 32'h0,        32'hCAFEF00D, 1'b0};
`else
    tv[8]  = '{1'b1, 9'h002, 2'b10, 32'h0,        32'hF00D1122, 1'b0};
    tv[9]  = '{1'b0, 9'h1FF, 2'b01, 32'h0000A55A, 32'h0,        1'b0};
    tv[10] = '{1'b1, 9'h1FF, 2'b00, 32'h0,        32'h000000A5, 1'b0};
    tv[11] = '{1'b1, 9'h000, 2'b00, 32'h0,        32'h0000005A, 1'b0};
    tv[12] = '{1'b1, 9'h1FF, 2'b01, 32'h0,        32'h0000A55A, 1'b0};
    tv[13] = '{1'b1, 9'h000, 2'b10, 32'h0,        32'h5AFEF00D, 1'b0};
`endif

    last_exp = 32'h0;
    for (int i = 0; i < 14; i++) begin
      do_req(tv[i].rw, tv[i].addr, tv[i].size, tv[i].din, 0, d, b);
      model_access(tv[i].rw, tv[i].addr, tv[i].size, tv[i].din, e, eb);
      e = (tv[i].rw || tv[i].exp_berr) ? tv[i].exp : last_exp;
      chk($sformatf("tbl%0d_dout", i), d, e);
      chk($sformatf("tbl%0d_berr", i), 32'(b), 32'(tv[i].exp_berr));
      last_exp = e;
    end

    do_req(1'b1, 9'h010, 2'b10, 32'h0, 5, d, b);
    model_access(1'b1, 9'h010, 2'b10, 32'h0, e, eb);
    chk("hold_read", d, e);

    // Abort: MFA dropped while BUSY; write must still commit, MFC pulses once.
    @(negedge Clk);
    memFuncActive = 1'b1;
    readWrite     = 1'b0;
    address       = 9'h080;
    dataSize      = 2'b10;
    dataIn        = 32'h0BADF00D;
    @(posedge Clk);
    @(negedge Clk);
    memFuncActive = 1'b0;
    n = 0;
    while (!memFuncComplete && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("abort_latency", 32'(n), 32'(LAT + 1));
    @(posedge Clk); #1;
    chk("abort_mfc_pulse", 32'(memFuncComplete), 32'd0);
    model_access(1'b0, 9'h080, 2'b10, 32'h0BADF00D, e, eb);
    do_req(1'b1, 9'h080, 2'b10, 32'h0, 0, d, b);
    model_access(1'b1, 9'h080, 2'b10, 32'h0, e, eb);
    chk("abort_commit", d, e);

    // Reset during BUSY of a write: outputs clear at once, write dropped.
    do_req(1'b1, 9'h010, 2'b10, 32'h0, 0, d, b);
    model_access(1'b1, 9'h010, 2'b10, 32'h0, e, eb);
    chk("pre_reset_read", d, e);
    @(negedge Clk);
    memFuncActive = 1'b1;
    readWrite     = 1'b0;
    address       = 9'h040;
    dataSize      = 2'b10;
    dataIn        = 32'h99887766;
    @(posedge Clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_dout", dataOut, 32'h0);
    chk("midrst_mfc", 32'(memFuncComplete), 32'd0);
    chk("midrst_berr", 32'(busError), 32'd0);
    memFuncActive = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("midrst_idle", 32'(memFuncComplete), 32'd0);
    model_dout = 32'h0;
    do_req(1'b1, 9'h040, 2'b10, 32'h0, 0, d, b);
    model_access(1'b1, 9'h040, 2'b10, 32'h0, e, eb);
    chk("midrst_dropped", d, e);

    for (int i = 0; i < 80; i++) begin
      logic        rw;
      logic [8:0]  a;
      logic [1:0]  sz;
      logic [31:0] din;
      rw  = 1'($urandom);
      a   = 9'($urandom);
      sz  = 2'($urandom_range(0, 3));
      din = $urandom;
      do_req(rw, a, sz, din, int'($urandom_range(0, 2)), d, b);
      model_access(rw, a, sz, din, e, eb);
      chk($sformatf("rnd%0d_dout", i), d, e);
      chk($sformatf("rnd%0d_berr", i), 32'(b), 32'(eb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder_512x8.md
Name: mem_responder_512x8

Overview:
- Memory-side responder for the MFA/MFC four-phase handshake that the control unit drives toward memory.
- Holds 512 bytes of storage and serves byte, halfword and word reads and writes in big-endian order.
- Response latency is parameterised, so the control unit's wait states are exercised.
- Drop-in peer of the datapath's RAM slot: address comes from the trap mux, write data from MDR, read data goes to MDR mux and IR.

Parameters:
- LATENCY, 2: Clk cycles spent in BUSY before MFC is asserted (legal 1..15).
- DEPTH, 512: storage size in bytes; power of two.
- AW, 9: address width, equal to log2(DEPTH).

Ports:
- Clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- memFuncActive  in  1  MFA, request from the control unit
- readWrite  in  1  1 = read, 0 = write
- address  in  AW  byte address of the MSB (big-endian)
- dataIn  in  32  write data, right-justified
- dataSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- dataOut  out  32  read data, right-justified, zero-extended
- memFuncComplete  out  1  MFC, completion to the control unit
- busError  out  1  pulses with MFC on an illegal dataSize

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; dataOut=0, memFuncComplete=0, busError=0, latency counter=0.
  - Storage is not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on MFA=1 at a rising edge:
  - capture address, dataSize, readWrite and dataIn into request registers.
  - load counter with LATENCY-1 and go to BUSY.
  - Inputs after capture are ignored until the next request.
- BUSY: decrement the counter each cycle. At 0:
  - Read: dataOut is assembled from the captured request.
  - Write: storage is updated.
  - Then MFC=1 and go to DONE.
  - Total latency is LATENCY+1 edges from the edge where MFA is sampled to the edge where MFC is high.
- DONE: hold MFC=1 and dataOut stable until MFA is sampled 0; then MFC=0 and go to IDLE.
  - A new request needs MFA low for at least one edge (no back-to-back without the return-to-zero phase).
- MFA dropped during BUSY (abort):
  - Finish the access, enter DONE, assert MFC for one cycle, then return to IDLE.
  - A write still commits.
- Sizes (big-endian; A = captured address; every byte index is taken mod DEPTH, so the top of memory wraps to 0):
  - Byte: dataOut[7:0]=mem[A]; a write stores dataIn[7:0].
  - Halfword: mem[A] is the MS byte, mem[A+1] the LS byte; dataOut[15:0]; a write stores dataIn[15:0].
  - Word: mem[A..A+3], MS byte first.
  - dataSize=11: no storage change, dataOut=0, busError=1 together with MFC.
- Unused upper dataOut bits read 0; sign extension is the datapath's job.
- dataOut is updated only on read completion; writes leave it unchanged.
- Reset asserted mid-transaction: FSM returns to IDLE at once.
  - A write not yet committed is dropped.
  - A write already committed is kept.

Optional Feature:
- MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword at an odd address, or word at an address not divisible by 4, is rejected.
  - The FSM still runs the full latency and returns MFC with busError=1.
  - No storage change; dataOut=0.
- Undefined: unaligned accesses are served byte by byte with wrap, as above.

Decomposition:
- Shared package:
  - dataSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BAD).
  - readWrite encodings (RW_READ=1, RW_WRITE=0).
  - FSM state encodings.
  - The control unit reuses these.
- One sub-module, mem_byte_lane_ctrl, is natural:
  - Combinational.
  - Maps captured size and address to four byte-lane addresses, write enables, and read-assembly selects.
  - Also produces the alignment/illegal flag.

Test Plan:
- Word write 0xDEADBEEF @0x010, then word read @0x010 (LATENCY=2) -> MFC high exactly 3 edges after MFA is sampled; dataOut=0xDEADBEEF; byte read @0x011 -> 0x000000AD.
- Halfword write 0xA55A @0x1FF, then byte reads @0x1FF and @0x000 -> 0x000000A5 and 0x0000005A (wrap); halfword read @0x1FF -> 0x0000A55A.
- dataSize=11 read @0x020 -> MFC with busError=1, dataOut=0, storage unchanged on a later word read.
- MFA held high after MFC -> MFC stays 1 and dataOut stays stable for 5 cycles; MFA low -> MFC=0 on the next edge; re-raise MFA the same cycle MFC falls -> the new request is captured only after one MFA-low edge.
- Word write begun, reset pulled low during BUSY -> outputs 0 immediately, FSM IDLE, target bytes keep their old values.
- With MEM_ALIGN_CHECK_EN, word read @0x002 -> busError=1, dataOut=0; without it -> bytes 0x002..0x005 are returned.
